// File: rtl/switch_seq_pkg.sv
// switch_seq_pkg: shared state encoding, mode constants and helpers for the switch sequencer
package switch_seq_pkg;
  typedef enum logic [2:0] {ST_OFF, ST_RUN, ST_DRAIN, ST_SWAP, ST_SETTLE} state_t;
  localparam logic MODE_FREQ = 1'b0;
  localparam logic MODE_CURR = 1'b1;
  function automatic logic is_busy(state_t s);
    return (s == ST_DRAIN) || (s == ST_SWAP) || (s == ST_SETTLE);
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter, done while the count is 1, holds at 0 instead of wrapping
module seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load on request, otherwise count down and stick at zero
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/switch_sequencer.sv
// switch_sequencer: break-before-make A/B routing switch sequencer; AUTO_SCAN_EN enables internal mode scanning
module switch_sequencer
  import switch_seq_pkg::*;
#(
  parameter int DEAD_CYC    = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int SCAN_PERIOD = 1000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic mode_req,
  input  logic drv_A,
  input  logic drv_B,
  output logic sel,
  output logic int_A,
  output logic int_B,
  output logic busy,
  output logic switch_done
);
  state_t state_q, state_d;
  logic sel_q, sel_d, int_a_q, int_a_d, int_b_q, int_b_d;
  logic busy_q, busy_d, done_q, done_d;
  logic tmr_load, tmr_done, target;
  logic [CNT_W-1:0] tmr_val;
`ifdef AUTO_SCAN_EN
  logic target_q, target_d;
  // flip the scan target on the last of SCAN_PERIOD consecutive RUN cycles
  always_comb target_d = (state_q == ST_RUN && enable && tmr_done) ?
                         ((target_q == MODE_CURR) ? MODE_FREQ : MODE_CURR) : target_q;
  // scan target register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) target_q <= MODE_FREQ;
    else target_q <= target_d;
  assign target = target_d;
`else
  assign target = mode_req;
`endif
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:    if (enable) state_d = (target == sel_q) ? ST_RUN : ST_DRAIN;
      ST_RUN:    if (!enable) state_d = ST_OFF;
                 else if (target != sel_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (!enable) state_d = ST_OFF;
                 else if (tmr_done) state_d = (target != sel_q) ? ST_SWAP : ST_RUN;
      ST_SWAP:   state_d = ST_SETTLE;
      ST_SETTLE: if (tmr_done) state_d = !enable ? ST_OFF : (target != sel_q) ? ST_DRAIN : ST_RUN;
      default:   state_d = ST_OFF;
    endcase
  end
  // timer reloads on every state change with the dwell length of the state being entered
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = (state_d == ST_DRAIN)  ? CNT_W'(DEAD_CYC) :
               (state_d == ST_SETTLE) ? CNT_W'(SETTLE_CYC) :
               (state_d == ST_RUN)    ? CNT_W'(SCAN_PERIOD) : '0;
  end
  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );
  // registered outputs derived from the next state so they line up with the state register
  always_comb begin
    sel_d   = (state_d == ST_SWAP && state_q != ST_SWAP) ?
              ((sel_q == MODE_CURR) ? MODE_FREQ : MODE_CURR) : sel_q;
    int_a_d = (state_d == ST_RUN) ? drv_A : 1'b0;
    int_b_d = (state_d == ST_RUN) ? drv_B : 1'b0;
    busy_d  = is_busy(state_d);
    done_d  = (state_q == ST_SETTLE) && (state_d == ST_RUN);
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_OFF;
      sel_q   <= MODE_FREQ;
      int_a_q <= 1'b0;
      int_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      int_a_q <= int_a_d;
      int_b_q <= int_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign sel         = sel_q;
  assign int_A       = int_a_q;
  assign int_B       = int_b_q;
  assign busy        = busy_q;
  assign switch_done = done_q;
endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: directed self-checking bench for switch_sequencer (AUTO_SCAN_EN selects the scan scenario)
module tb_switch_sequencer;
  logic clk, rst_n, enable, mode_req, drv_A, drv_B;
  logic sel, int_A, int_B, busy, switch_done;
  int checks = 0;
  int failures = 0;

  switch_sequencer #(.DEAD_CYC(4), .SETTLE_CYC(8), .SCAN_PERIOD(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_req(mode_req),
    .drv_A(drv_A), .drv_B(drv_B), .sel(sel), .int_A(int_A), .int_B(int_B),
    .busy(busy), .switch_done(switch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode_req = 1'b0; drv_A = 1'b0; drv_B = 1'b0;
    #2;
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_intA", int_A, 1'b0);
    chk("rst_intB", int_B, 1'b0);
    chk("rst_done", switch_done, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("off_intA", int_A, 1'b0);
    chk("off_busy", busy, 1'b0);
`ifdef AUTO_SCAN_EN
    enable = 1'b1; drv_A = 1'b1; drv_B = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      mode_req = 1'($urandom_range(0, 1));
      tick();
      chk("scan_run", int_A, (k <= 10) || (k >= 24 && k <= 33) || (k >= 47));
      chk("scan_sel", sel, (k >= 15) && (k < 38));
      chk("scan_done", switch_done, (k == 24) || (k == 47));
    end
`else
    enable = 1'b1; drv_A = 1'b1; drv_B = 1'b0;
    tick();
    chk("run_intA", int_A, 1'b1);
    chk("run_intB_low", int_B, 1'b0);
    chk("run_busy", busy, 1'b0);
    drv_B = 1'b1;
    tick();
    chk("run_intB", int_B, 1'b1);
    mode_req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk("sw_busy", busy, 1'b1);
      chk("sw_sel", sel, k >= 5);
      chk("sw_intA", int_A, 1'b0);
      chk("sw_intB", int_B, 1'b0);
      chk("sw_done_early", switch_done, 1'b0);
    end
    tick();
    chk("sw_done", switch_done, 1'b1);
    chk("sw_busy_end", busy, 1'b0);
    chk("sw_intB_run", int_B, 1'b1);
    chk("sw_sel_end", sel, 1'b1);
    tick();
    chk("sw_done_pulse", switch_done, 1'b0);
    mode_req = 1'b0;
    tick(14);
    chk("back_done", switch_done, 1'b1);
    chk("back_sel", sel, 1'b0);
    tick();
    mode_req = 1'b1;
    tick();
    chk("wd_busy1", busy, 1'b1);
    tick();
    mode_req = 1'b0;
    tick(2);
    chk("wd_busy4", busy, 1'b1);
    chk("wd_intA4", int_A, 1'b0);
    tick();
    chk("wd_busy5", busy, 1'b0);
    chk("wd_sel5", sel, 1'b0);
    chk("wd_intA5", int_A, 1'b1);
    for (int k = 0; k < 12; k++) begin
      chk("wd_sel", sel, 1'b0);
      chk("wd_done", switch_done, 1'b0);
      tick();
    end
    mode_req = 1'b1;
    tick(2);
    enable = 1'b0;
    tick();
    chk("dr_off_busy", busy, 1'b0);
    chk("dr_off_sel", sel, 1'b0);
    chk("dr_off_intA", int_A, 1'b0);
    tick();
    chk("off_hold_busy", busy, 1'b0);
    enable = 1'b1;
    tick();
    chk("off_drain_busy", busy, 1'b1);
    tick(4);
    chk("st_sel", sel, 1'b1);
    tick(2);
    enable = 1'b0;
    for (int k = 8; k <= 13; k++) begin
      tick();
      chk("st_busy", busy, 1'b1);
    end
    tick();
    chk("st_off_busy", busy, 1'b0);
    chk("st_off_sel", sel, 1'b1);
    chk("st_off_done", switch_done, 1'b0);
    chk("st_off_intA", int_A, 1'b0);
    enable = 1'b1; mode_req = 1'b0;
    tick(14);
    chk("r5_done", switch_done, 1'b1);
    chk("r5_sel", sel, 1'b0);
    mode_req = 1'b1;
    tick(8);
    chk("r5_busy_pre", busy, 1'b1);
    chk("r5_sel_pre", sel, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_sel", sel, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_intA", int_A, 1'b0);
    chk("ar_intB", int_B, 1'b0);
    chk("ar_done", switch_done, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
